mem_access_stage: RTL

- MEM pipeline stage. Sits between EX_MEM and MEM_WB.
- Holds the data memory and performs byte, half and word loads/stores with lane steering and sign extension.
- Drives the load data into MEM_WB's data-memory input.
- After reset, a clear sequencer zeroes the memory. A debug read port, a sticky misalignment flag and a committed-store counter are provided for the debug unit.

---
 rtl/mem_access_stage_pkg.sv | 24 ++
 rtl/load_extend.sv | 34 +++
 rtl/mem_access_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings and helpers for the MEM stage
package mem_access_stage_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Width 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
        logic result;
        if (width == WIDTH_BYTE) begin
            result = 1'b0;
        end else if (width == WIDTH_HALF) begin
            result = lane[0];
        end else begin
            result = (lane != 2'b00);
        end
        return result;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane selection and sign/zero extension of a loaded word
module load_extend
    import mem_access_stage_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic [NB-1:0] i_word,
    input  logic [1:0]    i_lane,
    input  logic [1:0]    i_width,
    input  logic          i_unsigned,
    output logic [NB-1:0] o_data
);

    logic [4:0]  shift;
    logic [15:0] part;
    logic        sign_byte;
    logic        sign_half;

    // Halves are selected by lane[1] only; an odd half lane is masked upstream.
    assign shift     = (i_width == WIDTH_HALF) ? {i_lane[1], 4'b0000} : {i_lane, 3'b000};
    assign part      = 16'(i_word >> shift);
    assign sign_byte = ~i_unsigned & part[7];
    assign sign_half = ~i_unsigned & part[15];

    always_comb begin
        o_data = i_word;
        if (i_width == WIDTH_BYTE) begin
            o_data = {{(NB-8){sign_byte}}, part[7:0]};
        end else if (i_width == WIDTH_HALF) begin
            o_data = {{(NB-16){sign_half}}, part[15:0]};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data memory, lane-steered loads/stores, clear sequencer
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int NB      = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_width,
    input  logic               i_unsigned,
    input  logic [NB-1:0]      i_alu_address_result,
    input  logic [NB-1:0]      i_write_data,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic [NB-1:0]      o_data_memory,
    output logic [NB-1:0]      o_debug_data,
    output logic               o_ready,
    output logic               o_misaligned,
    output logic               o_misaligned_sticky,
    output logic [NB_CNT-1:0]  o_store_count
);

    logic [NB-1:0]      mem [2**NB_ADDR];
    logic [0:0]         state;
    logic [NB_ADDR-1:0] clear_ptr;
    logic               ready;
    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         lane;
    logic               misaligned;
    logic               access;
    logic               commit;
    logic [NB-1:0]      cur_word;
    logic [NB-1:0]      merged;
    logic [NB-1:0]      loaded;
    logic               unused_addr_bits;

    // Address bits above the array wrap around.
    assign unused_addr_bits = ^i_alu_address_result[NB-1:NB_ADDR+2];

    assign word_idx   = i_alu_address_result[NB_ADDR+1:2];
    assign lane       = i_alu_address_result[1:0];
    assign ready      = (state == ST_READY);
    assign misaligned = is_misaligned(i_width, lane);
    assign access     = i_mem_read | i_mem_write;
    assign commit     = ready & i_step & i_mem_write & ~misaligned;
    assign cur_word   = mem[word_idx];

    always_comb begin
        merged = cur_word;
        if (i_width == WIDTH_BYTE) begin
            merged[{lane, 3'b000} +: 8] = i_write_data[7:0];
        end else if (i_width == WIDTH_HALF) begin
            merged[{lane[1], 4'b0000} +: 16] = i_write_data[15:0];
        end else begin
            merged = i_write_data;
        end
    end

    // Single write port shared by the clear sequencer and committed stores.
    always_ff @(posedge i_clk) begin
        if (!ready) begin
            mem[clear_ptr] <= '0;
        end else if (commit) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state               <= ST_CLEAR;
            clear_ptr           <= '0;
            o_misaligned_sticky <= 1'b0;
            o_store_count       <= '0;
        end else if (state == ST_CLEAR) begin
            clear_ptr <= clear_ptr + 1'b1;
            if (clear_ptr == '1) begin
                state <= ST_READY;
            end
        end else begin
            if (i_step & access & misaligned) begin
                o_misaligned_sticky <= 1'b1;
            end
            if (commit) begin
                o_store_count <= o_store_count + 1'b1;
            end
        end
    end

    load_extend #(
        .NB(NB)
    ) u_load_extend (
        .i_word    (cur_word),
        .i_lane    (lane),
        .i_width   (i_width),
        .i_unsigned(i_unsigned),
        .o_data    (loaded)
    );

    assign o_data_memory = (ready & i_mem_read & ~misaligned) ? loaded : '0;
    assign o_debug_data  = ready ? mem[i_debug_addr] : '0;
    assign o_ready       = ready;
    assign o_misaligned  = access & misaligned & ready;

endmodule
